// File: rtl/alu_multdiv.sv
// Multicycle signed multiply/divide beside the execute-stage ALU.
// One bit per cycle; fixed 33-cycle capture-to-ready latency.
module alu_multdiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0]    count;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] opnd;
  logic             op_div;
  logic             neg;
  logic             div_zero;

  logic             start;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;

  assign start = ctrl_MULT | ctrl_DIV;

  // Unsigned magnitudes: -2^31 maps cleanly to 2^31.
  assign a_abs = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1)
                                        : data_operandA;
  assign b_abs = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1)
                                        : data_operandB;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: next_state = IDLE;
      RUN: begin
        if (count == CW'(WIDTH - 1)) begin
          next_state = FIN;
        end
      end
      FIN: next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (start) begin
      next_state = RUN;
    end
  end

  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic [AW-1:0]    div_next;

  // Multiply: acc = {partial, multiplier}; add then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc[AW-1:WIDTH]}
             + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; restoring step.
  always_comb begin
    div_shift = acc[AW-1:WIDTH-1];
    div_diff  = {1'b0, div_shift} - {2'b00, opnd};
    if (!div_diff[WIDTH+1]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  logic [AW-1:0]    mul_signed;
  logic             mul_ovf;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div_res;
  logic             div_exc;
  logic [WIDTH-1:0] fin_res;
  logic             fin_exc;

  always_comb begin
    mul_signed = neg ? (~acc + 1'b1) : acc;
    mul_ovf    = (acc[AW-1:WIDTH] != '0)
               | (neg ? (acc[WIDTH-1] & (acc[WIDTH-2:0] != '0))
                      : acc[WIDTH-1]);
    quo        = acc[WIDTH-1:0];
    div_res    = neg ? (~quo + 1'b1) : quo;
    div_exc    = ~neg & quo[WIDTH-1];
    if (op_div) begin
      fin_res = div_zero ? '0 : div_res;
      fin_exc = div_zero | div_exc;
    end else begin
      fin_res = mul_signed[WIDTH-1:0];
      fin_exc = mul_ovf;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count          <= '0;
      acc            <= '0;
      opnd           <= '0;
      op_div         <= 1'b0;
      neg            <= 1'b0;
      div_zero       <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        op_div   <= ~ctrl_MULT;
        neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        div_zero <= (data_operandB == '0);
        count    <= '0;
        if (ctrl_MULT) begin
          opnd <= a_abs;
          acc  <= {{WIDTH{1'b0}}, b_abs};
        end else begin
          opnd <= b_abs;
          acc  <= {{WIDTH{1'b0}}, a_abs};
        end
      end else begin
        unique case (state)
          RUN: begin
            count <= count + 1'b1;
            acc   <= op_div ? div_next : mul_next;
          end
          FIN: begin
            data_result    <= fin_res;
            data_exception <= fin_exc;
            data_resultRDY <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_alu_multdiv.sv
// Directed scoreboard bench for alu_multdiv.
// Expected results queued at issue, popped on each ready pulse.
module tb_alu_multdiv;

  logic        clock;
  logic        reset_n;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  alu_multdiv dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          cap;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;
  int   cyc;
  logic prev_rdy;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every ready pulse must match the head entry.
  initial prev_rdy = 1'b0;
  always @(negedge clock) begin
    if (reset_n && data_resultRDY) begin
      chk("rdy_single_cycle", prev_rdy, 0);
      chk("busy_at_rdy", busy, 0);
      if (sb.size() == 0) begin
        chk("unexpected_rdy", data_resultRDY, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", data_result, e.res);
        chk("exception", data_exception, e.exc);
        chk("latency", cyc - e.cap, 33);
      end
    end
    prev_rdy = data_resultRDY;
  end

  task automatic issue(input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc);
    exp_t e;
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    e.res = res;
    e.exc = exc;
    e.cap = cyc + 1;
    sb.push_back(e);
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) begin
      @(negedge clock);
      #1;
    end
    chk("timeout_pending", sb.size(), 0);
    @(negedge clock);
  endtask

  task automatic run(input logic m, input logic d,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input logic exc);
    issue(m, d, a, b, res, exc);
    wait_done();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset_n       = 1'b0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(negedge clock);
    chk("reset_result", data_result, 0);
    chk("reset_exc", data_exception, 0);
    chk("reset_rdy", data_resultRDY, 0);
    chk("reset_busy", busy, 0);
    #1 reset_n = 1'b1;

    issue(1, 0, 32'd7, -32'sd6, 32'hFFFFFFD6, 0);
    chk("busy_running", busy, 1);
    wait_done();
    chk("busy_after", busy, 0);
    chk("rdy_dropped", data_resultRDY, 0);

    run(1, 0, 32'h00010000, 32'h00010000, 32'h0, 1);
    run(1, 0, 32'hFFFF8000, 32'h00010000, 32'h80000000, 0);
    run(1, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 0);
    run(1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(1, 0, 32'h80000000, 32'h00000001, 32'h80000000, 0);

    run(0, 1, -32'sd7, 32'd2, 32'hFFFFFFFD, 0);
    issue(0, 1, 32'd100, 32'd7, 32'd14, 0);
    chk("result_holds", data_result, 32'hFFFFFFFD);
    wait_done();
    run(0, 1, 32'd5, 32'd0, 32'h0, 1);
    run(0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run(0, 1, 32'h80000000, 32'd2, 32'hC0000000, 0);
    run(0, 1, 32'd0, 32'd5, 32'h0, 0);
    run(0, 1, 32'd100, -32'sd7, 32'hFFFFFFF2, 0);

    issue(1, 0, 32'd3, 32'd3, 32'd9, 0);
    repeat (8) @(negedge clock);
    sb.delete();
    issue(0, 1, 32'd9, 32'd3, 32'd3, 0);
    wait_done();
    run(1, 1, 32'd4, 32'd2, 32'd8, 0);

    issue(1, 0, 32'd5, 32'd5, 32'd25, 0);
    repeat (13) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_result", data_result, 0);
    chk("async_rst_exc", data_exception, 0);
    chk("async_rst_rdy", data_resultRDY, 0);
    chk("async_rst_busy", busy, 0);
    sb.delete();
    @(negedge clock);
    #1 reset_n = 1'b1;
    repeat (45) @(negedge clock);
    chk("idle_after_rst", busy, 0);
    run(1, 0, 32'd2, 32'd2, 32'd4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
